multi_packet_scoreboard: RTL and testbench
==========================================

# multi_packet_scoreboard

Parametrised successor to the single-packet scoreboard used in the composed FIFO/buffer proofs. It shadows an in-order DUT by tracking its occupancy, and can track up to NTRACK magic packets at the same time. Each packet is captured on a push qualified by `start`. When that packet reaches the head and is popped, the block compares it against the DUT's `data_out`. Mismatches are reported combinationally through `prop_signal` and are also latched in a sticky error flag for bounded-model-checking and simulation benches.

## Interface
- DEPTH, 8, DUT capacity in entries.
- WIDTH, 8, data width.
- NTRACK, 2, number of independent magic-packet trackers (≥1).
- CNTWID, $clog2(DEPTH)+1, occupancy/position counter width.
- IDXW, (NTRACK>1 ? $clog2(NTRACK) : 1), tracker index width.

- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- push  input  1  DUT write request.
- pop  input  1  DUT read request.
- start  input  1  marks the current push as a magic packet.
- data_in  input  WIDTH  data written to the DUT.
- data_out  input  WIDTH  data read from the DUT (sampled when a pop is effective).
- check_vld  output  1  a tracked packet exits this cycle.
- check_idx  output  IDXW  tracker exiting this cycle; 0 when !check_vld.
- exp_data  output  WIDTH  captured value of the exiting tracker; 0 when !check_vld.
- occ  output  CNTWID  shadow DUT occupancy.
- empty  output  1  occ == 0.
- full  output  1  occ == DEPTH.
- all_done  output  1  every tracker is in DONE.
- dropped  output  1  sticky: a start-push arrived while no tracker was IDLE.
- mismatch  output  1  sticky: some check failed.
- prop_signal  output  1  !check_vld | (exp_data == data_out).

## Operation
- Effective handshakes:
  - pop_eff = pop & (occ != 0); pops on empty are ignored.
  - push_eff = push & ((occ != DEPTH) | pop_eff); pushes on full are ignored unless a pop happens in the same cycle.
- Occupancy update: occ_next = occ + push_eff − pop_eff. Range is 0..DEPTH; it never wraps.
- Each tracker i has a state (IDLE, TRACKING, DONE), a `pos_i` counter [CNTWID] and a `pkt_i` register [WIDTH].
- IDLE→TRACKING:
  - Condition: start & push_eff, and i is the lowest-index IDLE tracker.
  - Actions: pkt_i ← data_in; pos_i ← occ − pop_eff + 1, which is the 1-based position from the head.
  - At most one capture per cycle.
- TRACKING behaviour:
  - On pop_eff with pos_i > 1: pos_i ← pos_i − 1.
  - On pop_eff with pos_i == 1: the packet exits. check_vld=1, check_idx=i, exp_data=pkt_i, and next state is DONE.
- Exclusivity: tracked positions are distinct, so at most one tracker exits per cycle.
- A tracker captured this cycle cannot exit in the same cycle.
- DONE is terminal until rst; trackers are not recycled.
- start & push_eff with no IDLE tracker sets `dropped` (sticky). No tracker state changes in that case.
- start & push ignored because the DUT is full: nothing is captured and `dropped` is not set.
- mismatch ← mismatch | (check_vld & (exp_data != data_out)).

## Timing
- Reset values (asserted for one or more cycles):
  - occ=0; every tracker IDLE with pos=0 and pkt=0.
  - mismatch=0, dropped=0.
  - Resulting outputs: check_vld=0, check_idx=0, exp_data=0, empty=1, full=0, all_done=0, prop_signal=1.
- Reset has priority over push/pop/start in the same cycle. Asserting reset mid-operation discards all tracking immediately.
- Combinational outputs, valid in the same cycle as the triggering pop_eff: check_vld, check_idx, exp_data, prop_signal, empty, full, all_done.
- `mismatch` rises one cycle after the failing check; `dropped` rises one cycle after the dropped start.
- Capture latency: a start-push in cycle t gives TRACKING from t+1.
- Exit timing: a packet pushed into an empty DUT at cycle t can exit on the first pop_eff at cycle ≥ t+1.
- Simultaneous push_eff and pop_eff: occ is unchanged.
  - Existing trackers still decrement.
  - A new capture gets pos = occ.

## Test plan
- Reset, then idle 3 cycles -> occ=0, empty=1, prop_signal=1, check_vld=0, all_done=0.
- NTRACK=2, DEPTH=8: push A1,A2(start,0x5A),A3,A4(start,0xC3); pop ×4 with data_out=A1,0x5A,A3,0xC3 -> check_vld on pops 2 (idx 0) and 4 (idx 1), mismatch=0, all_done=1 next cycle.
- Same sequence but data_out=0x5B on pop 2 -> prop_signal=0 that cycle, mismatch=1 from next cycle and held.
- Fill to 8 entries, push again with start=1 and pop=0 -> occ stays 8, full=1, no capture. Then push+pop together with start -> capture with pos=8, occ stays 8.
- NTRACK=2: three start-pushes -> third sets dropped=1 next cycle; trackers 0/1 are unaffected and both check correctly.
- Push/capture then pop on empty and assert rst mid-tracking -> pop on empty is ignored (occ stays 0); after rst all trackers are IDLE, occ=0, mismatch=0, and a fresh start-push captures into tracker 0.

Source files
------------

// File: rtl/multi_packet_scoreboard.sv
// Shadow scoreboard for an in-order DUT: tracks occupancy and up to NTRACK
// magic packets, comparing each one against data_out when it leaves the head.

module multi_packet_scoreboard_trk #(
    parameter int WIDTH  = 8,
    parameter int CNTWID = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cap,
    input  logic              pop_eff,
    input  logic [WIDTH-1:0]  cap_data,
    input  logic [CNTWID-1:0] cap_pos,
    output logic              idle,
    output logic              done,
    output logic              exit,
    output logic [WIDTH-1:0]  pkt
);
    typedef enum logic [1:0] {IDLE, TRACKING, DONE} trk_state_t;

    trk_state_t        state;
    logic [CNTWID-1:0] pos;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pos   <= '0;
            pkt   <= '0;
        end else begin
            case (state)
                IDLE: if (cap) begin
                    state <= TRACKING;
                    pkt   <= cap_data;
                    pos   <= cap_pos;
                end
                TRACKING: if (pop_eff) begin
                    if (pos == CNTWID'(1)) state <= DONE;
                    else                   pos   <= pos - CNTWID'(1);
                end
                default: ;
            endcase
        end
    end

    // Only a tracker already in TRACKING can exit, so a same-cycle capture never does.
    assign exit = (state == TRACKING) && pop_eff && (pos == CNTWID'(1));
    assign idle = (state == IDLE);
    assign done = (state == DONE);
endmodule

module multi_packet_scoreboard #(
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 8,
    parameter int NTRACK = 2,
    parameter int CNTWID = $clog2(DEPTH) + 1,
    parameter int IDXW   = (NTRACK > 1) ? $clog2(NTRACK) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              start,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [WIDTH-1:0]  data_out,
    output logic              check_vld,
    output logic [IDXW-1:0]   check_idx,
    output logic [WIDTH-1:0]  exp_data,
    output logic [CNTWID-1:0] occ,
    output logic              empty,
    output logic              full,
    output logic              all_done,
    output logic              dropped,
    output logic              mismatch,
    output logic              prop_signal
);
    logic                               pop_eff, push_eff, cap_go, any_idle;
    logic [CNTWID-1:0]                  cap_pos;
    logic [NTRACK-1:0]                  idle_vec, done_vec, exit_vec, cap_sel;
    logic [NTRACK-1:0][WIDTH-1:0]       pkt_vec;

    assign pop_eff  = pop && (occ != '0);
    assign push_eff = push && ((occ != CNTWID'(DEPTH)) || pop_eff);
    assign cap_go   = start && push_eff;
    assign any_idle = |idle_vec;
    // 1-based position from the head after this cycle's pop has been applied.
    assign cap_pos  = occ - CNTWID'(pop_eff) + CNTWID'(1);

    always_comb begin
        logic found;
        cap_sel = '0;
        found   = 1'b0;
        for (int i = 0; i < NTRACK; i++) begin
            if (idle_vec[i] && !found) begin
                cap_sel[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NTRACK; g++) begin : g_trk
        multi_packet_scoreboard_trk #(.WIDTH(WIDTH), .CNTWID(CNTWID)) u_trk (
            .clk      (clk),
            .rst      (rst),
            .cap      (cap_go && cap_sel[g]),
            .pop_eff  (pop_eff),
            .cap_data (data_in),
            .cap_pos  (cap_pos),
            .idle     (idle_vec[g]),
            .done     (done_vec[g]),
            .exit     (exit_vec[g]),
            .pkt      (pkt_vec[g])
        );
    end

    // Tracked positions are distinct, so at most one exit bit is set.
    always_comb begin
        check_idx = '0;
        exp_data  = '0;
        for (int i = 0; i < NTRACK; i++) begin
            if (exit_vec[i]) begin
                check_idx = IDXW'(i);
                exp_data  = pkt_vec[i];
            end
        end
    end

    assign check_vld   = |exit_vec;
    assign prop_signal = !check_vld || (exp_data == data_out);
    assign empty       = (occ == '0);
    assign full        = (occ == CNTWID'(DEPTH));
    assign all_done    = &done_vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ      <= '0;
            dropped  <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            occ <= occ + CNTWID'(push_eff) - CNTWID'(pop_eff);
            if (cap_go && !any_idle)           dropped  <= 1'b1;
            if (check_vld && !prop_signal)     mismatch <= 1'b1;
        end
    end
endmodule

// File: tb/tb_multi_packet_scoreboard.sv
// Randomised scoreboard bench: a tagged-queue model of the DUT contents predicts
// every check event; a negedge monitor pops and compares as the DUT reports them.

module tb_multi_packet_scoreboard;
    localparam int DEPTH  = 8;
    localparam int WIDTH  = 8;
    localparam int NTRACK = 2;
    localparam int CNTWID = $clog2(DEPTH) + 1;
    localparam int IDXW   = (NTRACK > 1) ? $clog2(NTRACK) : 1;

    logic              clk = 0;
    logic              rst, push, pop, start;
    logic [WIDTH-1:0]  data_in, data_out;
    logic              check_vld, empty, full, all_done, dropped, mismatch, prop_signal;
    logic [IDXW-1:0]   check_idx;
    logic [WIDTH-1:0]  exp_data;
    logic [CNTWID-1:0] occ;

    multi_packet_scoreboard #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NTRACK(NTRACK)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .start(start),
        .data_in(data_in), .data_out(data_out), .check_vld(check_vld),
        .check_idx(check_idx), .exp_data(exp_data), .occ(occ), .empty(empty),
        .full(full), .all_done(all_done), .dropped(dropped), .mismatch(mismatch),
        .prop_signal(prop_signal)
    );

    always #5 clk = ~clk;

    typedef struct { logic [WIDTH-1:0] data; int tag; } entry_t;
    typedef struct { int idx; logic [WIDTH-1:0] data; } chk_t;

    // Reference model: DUT contents as a queue, each entry tagged with its tracker (-1 = none).
    entry_t           dq[$];
    chk_t             exp_q[$];
    int               trk_st[NTRACK];   // 0 idle, 1 tracking, 2 done
    logic [WIDTH-1:0] trk_pkt[NTRACK];
    bit               m_dropped, m_mismatch;

    // Expected outputs for the current cycle, published to the monitor.
    bit armed = 0;
    bit e_vld, e_prop, e_all_done, e_dropped, e_mismatch;
    int e_occ;

    int tests = 0, fails = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        dq.delete();
        for (int i = 0; i < NTRACK; i++) begin trk_st[i] = 0; trk_pkt[i] = '0; end
        m_dropped = 0;
        m_mismatch = 0;
    endtask

    // Drive one cycle's inputs, publish the expected outputs, then advance the model.
    task automatic step(input bit r, input bit p, input bit q, input bit s,
                        input logic [WIDTH-1:0] di, input logic [WIDTH-1:0] dout);
        bit pe, we, alld;
        entry_t ent;
        int sel;
        rst = r; push = p; pop = q; start = s; data_in = di; data_out = dout;

        pe = q && (dq.size() > 0);
        we = p && ((dq.size() < DEPTH) || pe);
        e_occ = dq.size();
        e_dropped = m_dropped;
        e_mismatch = m_mismatch;
        alld = 1;
        for (int i = 0; i < NTRACK; i++) if (trk_st[i] != 2) alld = 0;
        e_all_done = alld;
        e_vld = pe && (dq[0].tag >= 0);
        e_prop = 1;
        if (e_vld) begin
            exp_q.push_back('{dq[0].tag, trk_pkt[dq[0].tag]});
            e_prop = (trk_pkt[dq[0].tag] == dout);
        end
        armed = 1;

        if (r) model_reset();
        else begin
            if (e_vld) begin
                trk_st[dq[0].tag] = 2;
                if (!e_prop) m_mismatch = 1;
            end
            if (pe) void'(dq.pop_front());
            if (we) begin
                ent.data = di;
                ent.tag = -1;
                if (s) begin
                    sel = -1;
                    for (int i = NTRACK - 1; i >= 0; i--) if (trk_st[i] == 0) sel = i;
                    if (sel < 0) m_dropped = 1;
                    else begin
                        trk_st[sel] = 1;
                        trk_pkt[sel] = di;
                        ent.tag = sel;
                    end
                end
                dq.push_back(ent);
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("occ", occ, e_occ);
            chk("empty", empty, e_occ == 0);
            chk("full", full, e_occ == DEPTH);
            chk("all_done", all_done, e_all_done);
            chk("dropped", dropped, e_dropped);
            chk("mismatch", mismatch, e_mismatch);
            chk("prop_signal", prop_signal, e_prop);
            chk("check_vld", check_vld, e_vld);
            if (check_vld) begin
                if (exp_q.size() == 0) chk("spurious_check", 1, 0);
                else begin
                    chk_t c;
                    c = exp_q.pop_front();
                    chk("check_idx", check_idx, c.idx);
                    chk("exp_data", exp_data, c.data);
                end
            end else begin
                chk("check_idx_idle", check_idx, 0);
                chk("exp_data_idle", exp_data, 0);
            end
        end
    end

    function automatic logic [WIDTH-1:0] head_or(input logic [WIDTH-1:0] d);
        return (dq.size() > 0) ? dq[0].data : d;
    endfunction

    initial begin
        rst = 1; push = 0; pop = 0; start = 0; data_in = '0; data_out = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        repeat (3) step(0, 0, 0, 0, 8'h00, 8'h00);

        // In-order sequence with two trackers, all correct.
        step(0, 1, 0, 0, 8'h11, 8'h00);
        step(0, 1, 0, 1, 8'h5A, 8'h00);
        step(0, 1, 0, 0, 8'h33, 8'h00);
        step(0, 1, 0, 1, 8'hC3, 8'h00);
        step(0, 0, 1, 0, 8'h00, 8'h11);
        step(0, 0, 1, 0, 8'h00, 8'h5A);
        step(0, 0, 1, 0, 8'h00, 8'h33);
        step(0, 0, 1, 0, 8'h00, 8'hC3);
        repeat (2) step(0, 0, 0, 0, 8'h00, 8'h00);

        // Same sequence with a corrupted readout on pop 2.
        step(1, 0, 0, 0, 8'h00, 8'h00);
        step(0, 1, 0, 0, 8'h11, 8'h00);
        step(0, 1, 0, 1, 8'h5A, 8'h00);
        step(0, 1, 0, 0, 8'h33, 8'h00);
        step(0, 1, 0, 1, 8'hC3, 8'h00);
        step(0, 0, 1, 0, 8'h00, 8'h11);
        step(0, 0, 1, 0, 8'h00, 8'h5B);
        step(0, 0, 1, 0, 8'h00, 8'h33);
        step(0, 0, 1, 0, 8'h00, 8'hC3);
        repeat (2) step(0, 0, 0, 0, 8'h00, 8'h00);

        // Full DUT: start-push alone is ignored, start-push with pop captures at pos DEPTH.
        step(1, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, 8'(8'h20 + i), 8'h00);
        step(0, 1, 0, 1, 8'h77, 8'h00);
        step(0, 1, 1, 1, 8'h99, head_or(8'h00));
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0, 8'h00, head_or(8'h00));
        step(0, 0, 0, 0, 8'h00, 8'h00);

        // Third start-push with only two trackers is dropped.
        step(1, 0, 0, 0, 8'h00, 8'h00);
        step(0, 1, 0, 1, 8'hA0, 8'h00);
        step(0, 1, 0, 1, 8'hA1, 8'h00);
        step(0, 1, 0, 1, 8'hA2, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 8'h00, head_or(8'h00));
        step(0, 0, 0, 0, 8'h00, 8'h00);

        // Pop on empty, then reset while tracking, then a fresh capture into tracker 0.
        step(1, 0, 0, 0, 8'h00, 8'h00);
        step(0, 0, 1, 0, 8'h00, 8'hEE);
        step(0, 1, 0, 1, 8'h42, 8'h00);
        step(0, 1, 0, 0, 8'h43, 8'h00);
        step(1, 0, 0, 0, 8'h00, 8'h00);
        step(0, 1, 0, 1, 8'h55, 8'h00);
        step(0, 0, 1, 0, 8'h00, 8'h55);
        step(0, 0, 0, 0, 8'h00, 8'h00);

        // Random traffic with occasional resets so trackers get reused.
        for (int n = 0; n < 3000; n++) begin
            bit r, p, q, s;
            logic [WIDTH-1:0] dout;
            r = ($urandom_range(0, 99) < 2);
            p = ($urandom_range(0, 99) < 55);
            q = ($urandom_range(0, 99) < 50);
            s = ($urandom_range(0, 99) < 25);
            dout = WIDTH'($urandom);
            if ($urandom_range(0, 9) != 0) dout = head_or(dout);
            step(r, p, q, s, WIDTH'($urandom), dout);
        end

        armed = 0;
        @(negedge clk);
        chk("pending_checks", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
